// File: rtl/bless_nic.sv
// bless_nic: network interface between a processing element and the local
// port of a bufferless BLESS router. Packets from the core are queued in a
// small FIFO and stamped with seq/src/age. Every flit the router ejects is
// registered and handed to the core, with statistics and a misroute flag.
module bless_nic #(
  parameter int                ADDR_W  = 2,
  parameter logic [ADDR_W-1:0] MY_ADDR = 2'b00,
  parameter int                SEQ_W   = 3,
  parameter int                AGE_W   = 4,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 4,
  parameter int                CNT_W   = 16,
  localparam int               CW      = 1 + SEQ_W + 2*ADDR_W + AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inj_valid,
  output logic              inj_ready,
  input  logic [ADDR_W-1:0] inj_dest,
  input  logic [DATA_W-1:0] inj_data,
  output logic [CW-1:0]     rtr_c,
  output logic [DATA_W-1:0] rtr_d,
  input  logic              rtr_gnt,
  input  logic [CW-1:0]     ej_c,
  input  logic [DATA_W-1:0] ej_d,
  output logic              ej_valid,
  output logic [ADDR_W-1:0] ej_src,
  output logic [SEQ_W-1:0]  ej_seq,
  output logic [AGE_W-1:0]  ej_age,
  output logic [DATA_W-1:0] ej_data,
  output logic [CNT_W-1:0]  inj_count,
  output logic [CNT_W-1:0]  ej_count,
  output logic              misroute
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Injection FIFO storage and pointers (extra MSB distinguishes full/empty)
  logic [ADDR_W-1:0] r_mem_dest [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];
  logic [PW:0]       r_wr_ptr;
  logic [PW:0]       r_rd_ptr;
  logic [SEQ_W-1:0]  r_seq_ctr;
  logic [AGE_W-1:0]  r_head_age;
  logic [CNT_W-1:0]  r_inj_count;

  // Ejection registers
  logic              r_ej_valid;
  logic [ADDR_W-1:0] r_ej_src;
  logic [SEQ_W-1:0]  r_ej_seq;
  logic [AGE_W-1:0]  r_ej_age;
  logic [DATA_W-1:0] r_ej_data;
  logic [CNT_W-1:0]  r_ej_count;
  logic              r_misroute;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_head_idx;
  logic              w_ej_vld;
  logic [SEQ_W-1:0]  w_ej_seq;
  logic [ADDR_W-1:0] w_ej_src;
  logic [ADDR_W-1:0] w_ej_dest;
  logic [AGE_W-1:0]  w_ej_age;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                      (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_head_idx = r_rd_ptr[PW-1:0];

  // Ready is forced low while reset is held so every output reads 0 then
  assign inj_ready  = rst & ~w_full;
  assign w_push     = inj_valid & inj_ready;
  assign w_pop      = ~w_empty & rtr_gnt;

  assign rtr_c = w_empty ? '0 :
                 {1'b1, r_mem_seq[w_head_idx], MY_ADDR, r_mem_dest[w_head_idx], r_head_age};
  assign rtr_d = w_empty ? '0 : r_mem_data[w_head_idx];

  assign w_ej_vld  = ej_c[CW-1];
  assign w_ej_seq  = ej_c[CW-2 -: SEQ_W];
  assign w_ej_src  = ej_c[AGE_W+2*ADDR_W-1 -: ADDR_W];
  assign w_ej_dest = ej_c[AGE_W+ADDR_W-1 -: ADDR_W];
  assign w_ej_age  = ej_c[AGE_W-1:0];

  // FIFO payload write; contents need no reset since the head is masked when empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dest[r_wr_ptr[PW-1:0]] <= inj_dest;
      r_mem_data[r_wr_ptr[PW-1:0]] <= inj_data;
      r_mem_seq[r_wr_ptr[PW-1:0]]  <= r_seq_ctr;
    end
  end

  // FIFO pointers and sequence stamp counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_seq_ctr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
        r_seq_ctr <= r_seq_ctr + SEQ_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Head age: restarts on pop, saturates while the router keeps deflecting us
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_age <= '0;
    end else if (w_pop) begin
      r_head_age <= '0;
    end else if (!w_empty && (r_head_age != AGE_MAX)) begin
      r_head_age <= r_head_age + AGE_ONE;
    end
  end

  // Saturating count of flits accepted by the router
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inj_count <= '0;
    end else if (w_pop && (r_inj_count != CNT_MAX)) begin
      r_inj_count <= r_inj_count + CNT_ONE;
    end
  end

  // Ejection capture; fields hold when no valid flit arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ej_valid <= 1'b0;
      r_ej_src   <= '0;
      r_ej_seq   <= '0;
      r_ej_age   <= '0;
      r_ej_data  <= '0;
    end else begin
      r_ej_valid <= w_ej_vld;
      if (w_ej_vld) begin
        r_ej_src  <= w_ej_src;
        r_ej_seq  <= w_ej_seq;
        r_ej_age  <= w_ej_age;
        r_ej_data <= ej_d;
      end
    end
  end

  // Ejection statistics and sticky misroute detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ej_count <= '0;
      r_misroute <= 1'b0;
    end else if (w_ej_vld) begin
      if (r_ej_count != CNT_MAX) begin
        r_ej_count <= r_ej_count + CNT_ONE;
      end
      if (w_ej_dest != MY_ADDR) begin
        r_misroute <= 1'b1;
      end
    end
  end

  assign ej_valid  = r_ej_valid;
  assign ej_src    = r_ej_src;
  assign ej_seq    = r_ej_seq;
  assign ej_age    = r_ej_age;
  assign ej_data   = r_ej_data;
  assign inj_count = r_inj_count;
  assign ej_count  = r_ej_count;
  assign misroute  = r_misroute;

endmodule

// File: tb/tb_bless_nic.sv
// Testbench for bless_nic: directed stimulus with a queue-based scoreboard.
// Stimulus tasks push expected flits; a negedge monitor pops and compares
// whenever the router accepts a flit or the core receives an ejected one.
module tb_bless_nic;

   localparam logic [1:0] MY_ADDR = 2'b00;

   typedef struct packed {
      logic [11:0] c;
      logic [31:0] d;
   } injExp_t;

   typedef struct packed {
      logic [1:0]  src;
      logic [2:0]  seq;
      logic [3:0]  age;
      logic [31:0] data;
   } ejExp_t;

   logic        clk;
   logic        rst;
   logic        injValid;
   logic        injReady;
   logic [1:0]  injDest;
   logic [31:0] injData;
   logic [11:0] rtrC;
   logic [31:0] rtrD;
   logic        rtrGnt;
   logic [11:0] ejC;
   logic [31:0] ejD;
   logic        ejValid;
   logic [1:0]  ejSrc;
   logic [2:0]  ejSeq;
   logic [3:0]  ejAge;
   logic [31:0] ejData;
   logic [15:0] injCount;
   logic [15:0] ejCount;
   logic        misroute;

   int testCount = 0;
   int failCount = 0;
   logic [2:0] tbSeq = 3'd0;
   injExp_t injQ[$];
   ejExp_t  ejQ[$];

   bless_nic #(.MY_ADDR(MY_ADDR)) dut (
      .clk(clk), .rst(rst),
      .inj_valid(injValid), .inj_ready(injReady),
      .inj_dest(injDest), .inj_data(injData),
      .rtr_c(rtrC), .rtr_d(rtrD), .rtr_gnt(rtrGnt),
      .ej_c(ejC), .ej_d(ejD),
      .ej_valid(ejValid), .ej_src(ejSrc), .ej_seq(ejSeq),
      .ej_age(ejAge), .ej_data(ejData),
      .inj_count(injCount), .ej_count(ejCount), .misroute(misroute)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Offer one packet for one cycle; records an expected flit if it was accepted
   task automatic applyStimulus(input logic [1:0] dest, input logic [31:0] data,
                                input logic [3:0] expAge, input logic expectAccept);
      injValid = 1'b1;
      injDest  = dest;
      injData  = data;
      #1;
      checkOutput("injReady", {63'd0, injReady}, {63'd0, expectAccept});
      if (injReady) begin
         injQ.push_back('{c: {1'b1, tbSeq, MY_ADDR, dest, expAge}, d: data});
         tbSeq = tbSeq + 3'd1;
      end
      @(posedge clk);
      #1;
      injValid = 1'b0;
   endtask

   // Present one flit on the router's local output for one cycle
   task automatic ejectFlit(input logic [11:0] c, input logic [31:0] d);
      ejC = c;
      ejD = d;
      if (c[11]) begin
         ejQ.push_back('{src: c[7:6], seq: c[10:8], age: c[3:0], data: d});
      end
      @(posedge clk);
      #1;
      ejC = 12'd0;
      ejD = 32'd0;
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard queues
   always @(negedge clk) begin : monitor
      injExp_t ie;
      ejExp_t  ee;
      if (rtrC[11] && rtrGnt) begin
         if (injQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL unexpectedInject: got rtr_c 0x%0h, expected no flit", rtrC);
         end else begin
            ie = injQ.pop_front();
            checkOutput("injCtrl", {52'd0, rtrC}, {52'd0, ie.c});
            checkOutput("injData", {32'd0, rtrD}, {32'd0, ie.d});
         end
      end
      if (ejValid) begin
         if (ejQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL unexpectedEject: got ej_data 0x%0h, expected no flit", ejData);
         end else begin
            ee = ejQ.pop_front();
            checkOutput("ejFields", {23'd0, ejSrc, ejSeq, ejAge, ejData},
                        {23'd0, ee.src, ee.seq, ee.age, ee.data});
         end
      end
   end

   // Directed test sequence
   initial begin
      rst      = 1'b0;
      injValid = 1'b0;
      injDest  = 2'd0;
      injData  = 32'd0;
      rtrGnt   = 1'b0;
      ejC      = 12'd0;
      ejD      = 32'd0;

      // Reset then idle
      #2;
      checkOutput("readyInReset", {63'd0, injReady}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("idleRtrC", {52'd0, rtrC}, 64'd0);
      checkOutput("idleRtrD", {32'd0, rtrD}, 64'd0);
      checkOutput("idleReady", {63'd0, injReady}, 64'd1);
      checkOutput("idleEjValid", {63'd0, ejValid}, 64'd0);
      checkOutput("idleCounts", {32'd0, injCount, ejCount}, 64'd0);
      checkOutput("idleMisroute", {63'd0, misroute}, 64'd0);

      // Single push with grant held: no fall-through, appears next cycle, popped
      @(posedge clk);
      #1;
      rtrGnt   = 1'b1;
      injValid = 1'b1;
      injDest  = 2'd1;
      injData  = 32'h0;
      #1;
      checkOutput("noFallThrough", {52'd0, rtrC}, 64'd0);
      applyStimulus(2'd1, 32'h0, 4'd0, 1'b1);
      checkOutput("headAfterPush", {52'd0, rtrC}, 64'h810);
      @(posedge clk);
      #1;
      checkOutput("injCount1", {48'd0, injCount}, 64'd1);
      applyStimulus(2'd2, 32'hAB, 4'd0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("injCount2", {48'd0, injCount}, 64'd2);

      // Fill with grant low, then watch the head age saturate
      rtrGnt = 1'b0;
      applyStimulus(2'd1, 32'h11, 4'd15, 1'b1);
      applyStimulus(2'd2, 32'h22, 4'd0, 1'b1);
      applyStimulus(2'd3, 32'h33, 4'd0, 1'b1);
      applyStimulus(2'd1, 32'h44, 4'd0, 1'b1);
      checkOutput("age3", {60'd0, rtrC[3:0]}, 64'd3);
      applyStimulus(2'd2, 32'h55, 4'd0, 1'b0);
      checkOutput("age4", {60'd0, rtrC[3:0]}, 64'd4);
      for (int k = 5; k <= 18; k++) begin
         @(posedge clk);
         #1;
         checkOutput("ageSat", {60'd0, rtrC[3:0]}, (k > 15) ? 64'd15 : 64'(k));
      end
      rtrGnt = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("drainedIdle", {52'd0, rtrC}, 64'd0);
      checkOutput("injCount6", {48'd0, injCount}, 64'd6);

      // Sequence wrap from a fresh reset: nine back-to-back packets
      rst = 1'b0;
      tbSeq = 3'd0;
      injQ.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(2'(i), 32'h100 + 32'(i), 4'd0, 1'b1);
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("injCount9", {48'd0, injCount}, 64'd9);

      // Ejection path, misroute, and concurrent injection/ejection
      ejectFlit(12'hBC5, 32'h3);
      checkOutput("ejValid1", {63'd0, ejValid}, 64'd1);
      checkOutput("ejCount1", {48'd0, ejCount}, 64'd1);
      checkOutput("noMisroute", {63'd0, misroute}, 64'd0);
      ejectFlit(12'h962, 32'h55);
      checkOutput("misrouteSet", {63'd0, misroute}, 64'd1);
      checkOutput("ejCount2", {48'd0, ejCount}, 64'd2);
      @(posedge clk);
      #1;
      checkOutput("ejValidLow", {63'd0, ejValid}, 64'd0);
      checkOutput("ejDataHold", {32'd0, ejData}, 64'h55);
      checkOutput("misrouteSticky", {63'd0, misroute}, 64'd1);
      fork
         applyStimulus(2'd3, 32'hCAFE, 4'd0, 1'b1);
         ejectFlit(12'hD81, 32'h77);
      join
      checkOutput("ejCount3", {48'd0, ejCount}, 64'd3);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("injCount10", {48'd0, injCount}, 64'd10);

      // Asynchronous reset mid-stream with three queued flits
      rtrGnt = 1'b0;
      applyStimulus(2'd1, 32'hA1, 4'd0, 1'b1);
      applyStimulus(2'd2, 32'hA2, 4'd0, 1'b1);
      applyStimulus(2'd3, 32'hA3, 4'd0, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("rstRtrC", {52'd0, rtrC}, 64'd0);
      checkOutput("rstRtrD", {32'd0, rtrD}, 64'd0);
      checkOutput("rstReady", {63'd0, injReady}, 64'd0);
      checkOutput("rstEj", {63'd0, ejValid}, 64'd0);
      checkOutput("rstCounts", {32'd0, injCount, ejCount}, 64'd0);
      checkOutput("rstMisroute", {63'd0, misroute}, 64'd0);
      injQ.delete();
      tbSeq = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("postRstReady", {63'd0, injReady}, 64'd1);
      checkOutput("postRstEmpty", {52'd0, rtrC}, 64'd0);
      rtrGnt = 1'b1;
      applyStimulus(2'd1, 32'h0, 4'd0, 1'b1);
      checkOutput("seqRestart", {52'd0, rtrC}, 64'h810);
      repeat (2) @(posedge clk);
      #1;

      checkOutput("injQEmpty", 64'(injQ.size()), 64'd0);
      checkOutput("ejQEmpty", 64'(ejQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/bless_nic.md
Name: bless_nic

Overview:
- Network interface that sits between a processing element and the local port (port 4) of a bufferless BLESS router.
- Injection side: buffers packets from the core in a small FIFO and stamps each one with seq, src and age. The head flit is presented on the router's local input; it is popped only when the router grants a free slot.
- Ejection side: registers every flit the router delivers on its local output and hands it to the core. There is no backpressure on ejection, because a bufferless router must drain every cycle.
- Also keeps injection/ejection statistics and a misroute error flag.

Parameters:
- MY_ADDR, 2'b00, node address stamped into src and checked against ejected dest
- ADDR_W, 2, address field width
- SEQ_W, 3, sequence field width
- AGE_W, 4, age field width
- DATA_W, 32, flit payload width
- DEPTH, 4, injection FIFO entries (power of two)
- CNT_W, 16, statistics counter width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- inj_valid  input  1  core offers a packet
- inj_ready  output  1  NIC accepts; transfer occurs when inj_valid & inj_ready on a rising edge
- inj_dest  input  ADDR_W  destination node
- inj_data  input  DATA_W  payload
- rtr_c  output  CW  control to router local input; CW = 1+SEQ_W+2*ADDR_W+AGE_W; packing MSB..LSB {valid, seq, src, dest, age}
- rtr_d  output  DATA_W  data to router local input
- rtr_gnt  input  1  router consumed the offered flit this cycle
- ej_c  input  CW  router local output control, same packing
- ej_d  input  DATA_W  router local output data
- ej_valid  output  1  ejected flit valid to core
- ej_src  output  ADDR_W  source of ejected flit
- ej_seq  output  SEQ_W  sequence of ejected flit
- ej_age  output  AGE_W  age of ejected flit
- ej_data  output  DATA_W  payload of ejected flit
- inj_count  output  CNT_W  flits accepted by router (saturating)
- ej_count  output  CNT_W  valid flits ejected (saturating)
- misroute  output  1  sticky: a valid flit was ejected with dest != MY_ADDR

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty, seq counter 0, head age 0.
  - All outputs 0; inj_ready is 1 once rst is high.
  - Reset mid-operation discards queued flits; no partial flit remains on rtr_c.
- Enqueue:
  - inj_ready = !full. There is no push-when-full, even with a same-cycle pop.
  - On push, the entry stores {dest, data, seq_ctr}; seq_ctr then increments modulo 2^SEQ_W (wraps 7->0).
- Head presentation (combinational from registered FIFO state):
  - rtr_c.valid = !empty; src = MY_ADDR; seq/dest/data from the head entry; age = head_age.
  - When empty, all of rtr_c and rtr_d is 0.
  - A push into an empty FIFO first appears on rtr_c the next cycle (no fall-through).
- Pop:
  - Occurs when rtr_c.valid & rtr_gnt. Head_age resets to 0 and inj_count increments, saturating at all-ones.
  - rtr_gnt while empty is ignored.
- Age:
  - Each cycle the head is valid and not granted, head_age increments, saturating at 2^AGE_W-1.
  - A new head always starts at age 0.
- Simultaneous push and pop (not full): both occur; occupancy is unchanged.
- Ejection, 1-cycle latency:
  - On each rising edge, ej_valid <= ej_c.valid, and ej_src/seq/age/data <= fields of ej_c/ej_d.
  - When ej_c.valid = 0, ej_valid = 0 and the data fields hold their previous value.
  - Each valid ejection increments ej_count, saturating.
  - A valid ejection with ej_c.dest != MY_ADDR sets misroute; it stays set until reset. The flit is still delivered to the core.
- Ejection and injection operate independently in the same cycle.

Test Plan:
- Reset then idle: rtr_c = 0, ej_valid = 0, inj_ready = 1, counters 0, misroute 0.
- MY_ADDR=0, push dest=1 data=0x0 with rtr_gnt held 1:
  - rtr_c = {1,3'd0,2'd0,2'd1,4'd0} appears 1 cycle after the push and is popped the same cycle.
  - inj_count = 1; the next push carries seq 1.
- Fill, then stall and age:
  - Push 5 packets with rtr_gnt = 0: inj_ready drops after 4.
  - Head age reads 1,2,… and saturates at 15 after 15 stalled cycles.
  - After rtr_gnt, the next head shows age 0.
- Sequence wrap: 9 packets pushed and drained carry seq 0..7 then 0.
- Ejection of ej_c = {1,3'd3,2'd3,2'd0,4'd5}, ej_d = 0x3 at MY_ADDR=0:
  - Next cycle ej_valid = 1, src = 3, seq = 3, age = 5, data = 0x3; ej_count = 1.
  - A following flit with dest = 2 sets misroute, which stays 1.
- Assert rst low mid-stream with 3 queued flits: outputs are 0 immediately, without waiting for a clock edge. After release the FIFO is empty and seq restarts at 0.
